// File: rtl/s2p_frame.sv
// rtl/s2p_frame.sv - serial-to-parallel 8-word frame collector for the FFT input
// Optional S2P_BITREV_EN: load q1..q8 in bit-reversed word order for DIT FFT.
module s2p_frame #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7,
   output logic [WIDTH-1:0] q8,
   output logic             valid,
   output logic [2:0]       cnt
);

   logic [WIDTH-1:0] sbuf  [8];
   logic [WIDTH-1:0] qr    [8];
   logic [WIDTH-1:0] frame [8];

   function automatic logic [2:0] src_idx(input logic [2:0] j);
`ifdef S2P_BITREV_EN
      return {j[0], j[1], j[2]};
`else
      return j;
`endif
   endfunction

   // Word 7 bypasses the buffer so the frame loads on the edge that accepts it.
   always_comb begin
      for (int j = 0; j < 8; j++) begin
         if (src_idx(3'(j)) == 3'd7)
            frame[j] = din;
         else
            frame[j] = sbuf[src_idx(3'(j))];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= 3'd0;
         valid <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            sbuf[i] <= '0;
            qr[i]   <= '0;
         end
      end else begin
         valid <= 1'b0;
         if (sync) begin
            cnt <= en ? 3'd1 : 3'd0;
            if (en)
               sbuf[0] <= din;
         end else if (en) begin
            sbuf[cnt] <= din;
            cnt       <= cnt + 3'd1;
            if (cnt == 3'd7) begin
               valid <= 1'b1;
               for (int i = 0; i < 8; i++)
                  qr[i] <= frame[i];
            end
         end
      end
   end

   assign q1 = qr[0];
   assign q2 = qr[1];
   assign q3 = qr[2];
   assign q4 = qr[3];
   assign q5 = qr[4];
   assign q6 = qr[5];
   assign q7 = qr[6];
   assign q8 = qr[7];

endmodule

// File: doc/s2p_frame.md
# s2p_frame

Serial-to-parallel frame collector for the 8-point FFT datapath. It accepts one 16-bit sample per enabled clock, assembles eight consecutive samples into a frame, and presents all eight words at once on parallel outputs with a one-cycle valid pulse. It sits at the FFT input, consuming the serial sample stream, and is the counterpart of the parallel-to-serial output stage.

## Interface
- `WIDTH`, 16, sample width in bits (all data ports).
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `en` input 1: sample strobe; `din` is captured on a rising edge where `en`=1.
- `sync` input 1: frame resynchronisation; discards any partial frame.
- `din` input WIDTH: serial sample word.
- `q1`..`q8` output WIDTH each: parallel frame words, registered.
- `valid` output 1: one-cycle pulse, frame on `q1`..`q8` is new.
- `cnt` output 3: number of words accepted into the current partial frame (0..7).

## Operation
- Internal state:
  - 3-bit word counter `cnt`.
  - Collection buffer `buf[0..7]` of WIDTH each.
  - Output registers `q1`..`q8`, which double-buffer the frame.
- Accept (`en`=1, `sync`=0):
  - `buf[cnt] <= din`.
  - `cnt <= cnt+1`, wrapping 7 -> 0.
- Frame complete (accept while `cnt`=7):
  - `q1..q8` load the eight frame words in one edge. Word k (0-based arrival order) goes to `q(k+1)`, and word 7 is taken directly from `din`.
  - `valid <= 1` for exactly one cycle.
  - `cnt` returns to 0.
- Idle (`en`=0, `sync`=0): all state holds. Gaps between accepted words are unlimited and do not affect assembly.
- `sync`=1:
  - `cnt <= 0`; the partial `buf` contents are abandoned.
  - If `en`=1 in the same cycle, `din` is captured as word 0 of the new frame (`buf[0] <= din`, `cnt <= 1`).
  - `sync` never produces `valid`, and never alters `q1..q8`.
- Outputs `q1..q8` hold the last completed frame until the next frame completes. Collection of the next frame proceeds in parallel with holding.
- No backpressure: the downstream stage must sample `q1..q8` while or after `valid` is high, before the next frame completes.

## Timing
- Reset (`rst`=1, asynchronous): `q1..q8`=0, `valid`=0, `cnt`=0, `buf` cleared. Any partial frame is discarded.
- Latency: `valid` and the new `q1..q8` appear on the clock edge that captures word 7. They are visible in the cycle following that edge.
- Back-to-back frames (`en` held high): `valid` pulses once every 8 cycles. It never stretches to two cycles.
- `valid` deasserts the cycle after the pulse, unless another frame completes on that edge (impossible for 8 words; stated for completeness).
- Reset mid-frame: frame lost, no `valid`. The first accepted word after `rst` deasserts is word 0.
- `sync` and the word-7 accept in the same cycle: `sync` wins. No frame completes and `din` becomes word 0.

## Configuration
- `S2P_BITREV_EN` defined: outputs are loaded in bit-reversed index order for the decimation-in-time FFT.
  - `q1..q8` = words 0,4,2,6,1,5,3,7.
  - All timing is unchanged.
- `S2P_BITREV_EN` undefined: natural order, `q(k+1)` = word k.

## Test plan
- Reset release, then `en`=1 for 8 cycles with `din`=1234,5678,ABCD,CDEF,0123,7894,1987,4561 (hex) -> one `valid` pulse after the 8th edge. `q1..q8` equal those values in order (bit-reversed build: 1234,0123,ABCD,1987,5678,7894,CDEF,4561).
- Same 8 words with `en` low for 3 cycles between words 3 and 4 -> identical `q1..q8`. `valid` pulses only after word 7. `cnt` holds at 4 during the gap.
- 16 consecutive words 0001..0010 -> `valid` pulses exactly twice, 8 cycles apart. After the second pulse, `q1`=0009 and `q8`=0010, and `q1..q8` hold until then.
- 5 words, then `sync`=1 with `en`=1 and `din`=AAAA, then 7 more words -> single `valid`, `q1`=AAAA. The five pre-sync words never appear on the outputs.
- `rst` pulsed asynchronously (mid-cycle) after 6 words -> `q1..q8`=0, `cnt`=0, `valid` stays 0. A following full frame assembles correctly from word 0.
- `sync`=1 coinciding with word 7 -> no `valid`, `cnt`=1, previous `q1..q8` unchanged.
